// File: rtl/icache_fetch_pkg.sv
// Shared definitions for the instruction-fetch cache.
//   state_t   : fetch FSM encoding (RUN / MISS / HOLD)
//   OP_*      : opcode[6:0] values of control-flow instructions
//   ZERO_WORD : reset value for instruction/address registers
//   is_ctrl() : true when an opcode redirects control flow
package icache_fetch_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_MISS = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  function automatic logic is_ctrl(input logic [6:0] op);
    return (op == OP_JAL) || (op == OP_JALR) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/icache_dm_array.sv
// Direct-mapped line storage: one valid bit, tag and data word per line.
//   clk, rst          : clock, synchronous active-high reset (clears valids)
//   inv_all           : clear every valid bit; wins over a same-cycle write
//   we/wr_idx/wr_tag/wr_data : line fill port
//   rd_idx -> rd_valid/rd_tag/rd_data : combinational lookup port
module icache_dm_array #(
  parameter int TAG_W  = 22,
  parameter int INST_W = 32,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inv_all,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [INST_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [INST_W-1:0] rd_data
);

  localparam int LINES = 1 << IDX_W;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [INST_W-1:0] data_q [LINES];

  // Bulk invalidate has priority so a fill landing with fence.i is dropped.
  always_ff @(posedge clk) begin
    if (rst)          valid_q <= '0;
    else if (inv_all) valid_q <= '0;
    else if (we)      valid_q[wr_idx] <= 1'b1;
  end

  // Tag/data need no reset; they are only trusted under a set valid bit.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache_fetch.sv
// Instruction fetch stage with a direct-mapped single-word-line cache.
//   clk, rst, rdy        : clock, sync active-high reset, global enable
//   pc_i, pc_valid       : fetch request from the PC register
//   flush, ctrl_done     : redirect / control-flow resolved pulse
//   inv_all              : invalidate whole cache
//   pc_o, inst_o, inst_valid : delivered instruction (1-cycle pulse)
//   stall                : PC register must hold
//   mem_req, mem_addr    : miss request (level, held until mem_done)
//   mem_data, mem_done   : fill response
module icache_fetch
  import icache_fetch_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int INST_W     = 32,
  parameter int IDX_W      = 8,
  parameter int CTRL_STALL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              pc_valid,
  input  logic              flush,
  input  logic              ctrl_done,
  input  logic              inv_all,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic              inst_valid,
  output logic              stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic [INST_W-1:0] mem_data,
  input  logic              mem_done
);

  localparam int TAG_W = ADDR_W - IDX_W - 2;

  state_t            state;
  logic              flush_pend;  // flush seen while the fill was in flight
  logic              done_cap;    // mem_done arrived while rdy was low
  logic [INST_W-1:0] data_cap;

  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [INST_W-1:0] rd_data;
  logic              hit;
  logic              fill_done;
  logic [INST_W-1:0] fill_data;
  logic              unused_lsb;

  // Word-aligned lines: byte offset bits never take part in lookup.
  assign unused_lsb = ^{pc_i[1:0], mem_addr[1:0]};

  assign hit       = rd_valid && (rd_tag == pc_i[ADDR_W-1:IDX_W+2]);
  assign fill_done = (state == ST_MISS) && (mem_done || done_cap);
  assign fill_data = done_cap ? data_cap : mem_data;
  assign stall     = (state != ST_RUN) || (pc_valid && !hit);

  icache_dm_array #(
    .TAG_W (TAG_W),
    .INST_W(INST_W),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .inv_all (rdy && inv_all),
    .we      (rdy && fill_done),
    .wr_idx  (mem_addr[IDX_W+1:2]),
    .wr_tag  (mem_addr[ADDR_W-1:IDX_W+2]),
    .wr_data (fill_data),
    .rd_idx  (pc_i[IDX_W+1:2]),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      pc_o       <= '0;
      inst_o     <= INST_W'(ZERO_WORD);
      inst_valid <= 1'b0;
      mem_addr   <= '0;
      mem_req    <= 1'b0;
      flush_pend <= 1'b0;
      done_cap   <= 1'b0;
      data_cap   <= '0;
    end else if (rdy) begin
      inst_valid <= 1'b0;
      case (state)
        ST_RUN: begin
          if (pc_valid && !flush) begin
            if (hit) begin
              pc_o       <= pc_i;
              inst_o     <= rd_data;
              inst_valid <= 1'b1;
              // A resolve pulse coinciding with the decision cancels the hold.
              if (CTRL_STALL != 0 && is_ctrl(rd_data[6:0]) && !ctrl_done)
                state <= ST_HOLD;
            end else begin
              mem_req  <= 1'b1;
              mem_addr <= pc_i;
              state    <= ST_MISS;
            end
          end
        end
        ST_MISS: begin
          if (flush) flush_pend <= 1'b1;
          if (fill_done) begin
            mem_req    <= 1'b0;
            done_cap   <= 1'b0;
            flush_pend <= 1'b0;
            state      <= ST_RUN;
            // Line is written regardless; only delivery is dropped on flush.
            if (!flush && !flush_pend) begin
              pc_o       <= mem_addr;
              inst_o     <= fill_data;
              inst_valid <= 1'b1;
              if (CTRL_STALL != 0 && is_ctrl(fill_data[6:0]) && !ctrl_done)
                state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (flush || ctrl_done) state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end else if (state == ST_MISS && mem_done) begin
      // Frozen: remember the response so it is consumed once rdy returns.
      done_cap <= 1'b1;
      data_cap <= mem_data;
    end
  end

endmodule

// File: tb/tb_icache_fetch.sv
module tb_icache_fetch;

  logic        clk = 1'b0;
  logic        rst, rdy, pc_valid, flush, ctrl_done, inv_all, mem_done;
  logic [31:0] pc_i, mem_data;
  logic [31:0] pc_o, inst_o, mem_addr, pc_o0, inst_o0, mem_addr0;
  logic        inst_valid, stall, mem_req, inst_valid0, stall0, mem_req0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  icache_fetch #(.CTRL_STALL(1)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .pc_i(pc_i), .pc_valid(pc_valid),
    .flush(flush), .ctrl_done(ctrl_done), .inv_all(inv_all),
    .pc_o(pc_o), .inst_o(inst_o), .inst_valid(inst_valid), .stall(stall),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_data(mem_data), .mem_done(mem_done));

  icache_fetch #(.CTRL_STALL(0)) dut0 (
    .clk(clk), .rst(rst), .rdy(rdy), .pc_i(pc_i), .pc_valid(pc_valid),
    .flush(flush), .ctrl_done(ctrl_done), .inv_all(inv_all),
    .pc_o(pc_o0), .inst_o(inst_o0), .inst_valid(inst_valid0), .stall(stall0),
    .mem_addr(mem_addr0), .mem_req(mem_req0), .mem_data(mem_data), .mem_done(mem_done));

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Miss on addr, then answer immediately; returns just after the fill edge.
  task automatic fill(input logic [31:0] addr, input logic [31:0] data);
    pc_i = addr; pc_valid = 1'b1;
    tick;
    pc_valid = 1'b0; mem_done = 1'b1; mem_data = data;
    tick;
    mem_done = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; rdy = 1'b1; pc_valid = 1'b0; flush = 1'b0; ctrl_done = 1'b0;
    inv_all = 1'b0; mem_done = 1'b0; pc_i = '0; mem_data = '0;
    tick; tick;
    rst = 1'b0; #1;
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_inst_valid: got %b want 0", inst_valid); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", stall); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
    total++; if ({pc_o, inst_o, mem_addr} !== 96'h0) begin bad++; $display("FAIL rst_regs: got %h %h %h want 0", pc_o, inst_o, mem_addr); end
  endtask

  task automatic test_cold_miss;
    tick;
    pc_i = 32'h10; pc_valid = 1'b1; #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL cold_stall_same_cycle: got %b want 1", stall); end
    tick;
    pc_valid = 1'b0;
    total++; if (mem_addr !== 32'h10) begin bad++; $display("FAIL cold_mem_addr: got %h want 00000010", mem_addr); end
    for (int i = 0; i < 3; i++) begin
      total++; if ({mem_req, stall, inst_valid} !== 3'b110) begin bad++; $display("FAIL cold_miss_cycle%0d: got req/stall/vld %b want 110", i, {mem_req, stall, inst_valid}); end
      if (i == 2) begin mem_done = 1'b1; mem_data = 32'h13; end
      tick;
    end
    mem_done = 1'b0; mem_data = 32'hDEAD_BEEF;
    total++; if ({inst_valid, mem_req} !== 2'b10) begin bad++; $display("FAIL cold_deliver: got vld/req %b want 10", {inst_valid, mem_req}); end
    total++; if (inst_o !== 32'h13 || pc_o !== 32'h10) begin bad++; $display("FAIL cold_data: got %h@%h want 00000013@00000010", inst_o, pc_o); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL cold_stall_after: got %b want 0", stall); end
    tick;
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL cold_pulse_once: got %b want 0", inst_valid); end
    pc_i = 32'h10; pc_valid = 1'b1; #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL hit_stall: got %b want 0", stall); end
    tick;
    pc_valid = 1'b0;
    total++; if ({inst_valid, mem_req} !== 2'b10 || inst_o !== 32'h13 || pc_o !== 32'h10) begin bad++; $display("FAIL hit_deliver: got vld/req %b %h@%h want 10 00000013@00000010", {inst_valid, mem_req}, inst_o, pc_o); end
  endtask

  task automatic test_alias;
    tick;
    pc_i = 32'h410; pc_valid = 1'b1; #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL alias_miss: got %b want 1", stall); end
    pc_valid = 1'b0;
    fill(32'h410, 32'h0010_0093);
    total++; if (inst_valid !== 1'b1 || inst_o !== 32'h0010_0093 || pc_o !== 32'h410) begin bad++; $display("FAIL alias_fill: got %b %h@%h want 1 00100093@00000410", inst_valid, inst_o, pc_o); end
    tick;
    pc_i = 32'h10; pc_valid = 1'b1; #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL alias_evicted: got %b want 1", stall); end
    tick;
    pc_valid = 1'b0;
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin bad++; $display("FAIL alias_refill_req: got %b %h want 1 00000010", mem_req, mem_addr); end
    mem_done = 1'b1; mem_data = 32'h13;
    tick;
    mem_done = 1'b0;
    total++; if (inst_valid !== 1'b1 || inst_o !== 32'h13) begin bad++; $display("FAIL alias_refill: got %b %h want 1 00000013", inst_valid, inst_o); end
  endtask

  task automatic test_ctrl_hold;
    tick;
    fill(32'h20, 32'h0000_006F);
    total++; if (inst_valid !== 1'b1 || inst_o !== 32'h6F) begin bad++; $display("FAIL jal_deliver: got %b %h want 1 0000006f", inst_valid, inst_o); end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL jal_hold_stall: got %b want 1", stall); end
    total++; if (stall0 !== 1'b0 || inst_valid0 !== 1'b1) begin bad++; $display("FAIL jal_nohold_cfg0: got stall %b vld %b want 0 1", stall0, inst_valid0); end
    tick; tick;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL jal_hold_persist: got %b want 1", stall); end
    ctrl_done = 1'b1; #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL jal_hold_done_cycle: got %b want 1", stall); end
    tick;
    ctrl_done = 1'b0;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL jal_release: got %b want 0", stall); end
    // Resolve pulse in the same cycle as the hit that would enter HOLD.
    pc_i = 32'h20; pc_valid = 1'b1; ctrl_done = 1'b1;
    tick;
    pc_valid = 1'b0; ctrl_done = 1'b0; #1;
    total++; if (inst_valid !== 1'b1 || stall !== 1'b0) begin bad++; $display("FAIL jal_same_cycle_done: got vld %b stall %b want 1 0", inst_valid, stall); end
    tick;
    pc_valid = 1'b1;
    tick;
    pc_valid = 1'b0; #1;
    total++; if (inst_valid !== 1'b1 || stall !== 1'b1) begin bad++; $display("FAIL jal_hit_hold: got vld %b stall %b want 1 1", inst_valid, stall); end
    ctrl_done = 1'b1;
    tick;
    ctrl_done = 1'b0;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL jal_hit_release: got %b want 0", stall); end
  endtask

  task automatic test_flush;
    tick;
    pc_i = 32'h30; pc_valid = 1'b1;
    tick;
    pc_valid = 1'b0; flush = 1'b1;
    tick;
    flush = 1'b0;
    tick;
    mem_done = 1'b1; mem_data = 32'h113;
    tick;
    mem_done = 1'b0;
    total++; if ({inst_valid, mem_req, stall} !== 3'b000) begin bad++; $display("FAIL flush_miss_suppress: got vld/req/stall %b want 000", {inst_valid, mem_req, stall}); end
    tick;
    pc_i = 32'h30; pc_valid = 1'b1; #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_fill_written: got stall %b want 0", stall); end
    tick;
    total++; if (inst_valid !== 1'b1 || inst_o !== 32'h113 || pc_o !== 32'h30) begin bad++; $display("FAIL flush_refetch: got %b %h@%h want 1 00000113@00000030", inst_valid, inst_o, pc_o); end
    flush = 1'b1;
    tick;
    flush = 1'b0; pc_valid = 1'b0;
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL flush_run_suppress: got %b want 0", inst_valid); end
  endtask

  task automatic test_rdy_freeze;
    tick;
    pc_i = 32'h40; pc_valid = 1'b1;
    tick;
    pc_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rdy = 1'b0;
      mem_done = (i == 1);
      mem_data = (i == 1) ? 32'h213 : 32'hDEAD_BEEF;
      tick;
      total++; if ({mem_req, stall, inst_valid} !== 3'b110 || mem_addr !== 32'h40) begin bad++; $display("FAIL rdy_frozen%0d: got req/stall/vld %b addr %h want 110 00000040", i, {mem_req, stall, inst_valid}, mem_addr); end
    end
    mem_done = 1'b0; rdy = 1'b1;
    tick;
    total++; if (inst_valid !== 1'b1 || inst_o !== 32'h213 || pc_o !== 32'h40 || mem_req !== 1'b0) begin bad++; $display("FAIL rdy_resume: got %b %h@%h req %b want 1 00000213@00000040 0", inst_valid, inst_o, pc_o, mem_req); end
  endtask

  task automatic test_inv_all;
    logic [31:0] addrs [4];
    addrs[0] = 32'h100; addrs[1] = 32'h104; addrs[2] = 32'h108; addrs[3] = 32'h10C;
    for (int i = 0; i < 4; i++) begin tick; fill(addrs[i], 32'h13 + (i << 7)); end
    tick;
    pc_i = 32'h100; pc_valid = 1'b1; inv_all = 1'b1;
    tick;
    pc_valid = 1'b0; inv_all = 1'b0;
    total++; if (inst_valid !== 1'b1 || inst_o !== 32'h13) begin bad++; $display("FAIL inv_same_cycle_hit: got %b %h want 1 00000013", inst_valid, inst_o); end
    for (int i = 0; i < 4; i++) begin
      pc_i = addrs[i]; pc_valid = 1'b1; #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL inv_refetch%0d: got stall %b want 1", i, stall); end
      pc_valid = 1'b0;
      tick;
    end
    // A fill completing together with inv_all is delivered but not kept.
    pc_i = 32'h200; pc_valid = 1'b1;
    tick;
    pc_valid = 1'b0; mem_done = 1'b1; mem_data = 32'h313; inv_all = 1'b1;
    tick;
    mem_done = 1'b0; inv_all = 1'b0;
    total++; if (inst_valid !== 1'b1 || inst_o !== 32'h313) begin bad++; $display("FAIL inv_fill_deliver: got %b %h want 1 00000313", inst_valid, inst_o); end
    pc_i = 32'h200; pc_valid = 1'b1; #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL inv_fill_cleared: got stall %b want 1", stall); end
    pc_valid = 1'b0;
  endtask

  task automatic test_rst_mid_miss;
    tick;
    pc_i = 32'h300; pc_valid = 1'b1;
    tick;
    pc_valid = 1'b0;
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rstmiss_req: got %b want 1", mem_req); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    total++; if (mem_req !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL rstmiss_abandon: got req %b stall %b want 0 0", mem_req, stall); end
    tick;
    mem_done = 1'b1; mem_data = 32'h6F;
    tick;
    mem_done = 1'b0;
    total++; if ({inst_valid, mem_req, stall} !== 3'b000) begin bad++; $display("FAIL rstmiss_stray: got vld/req/stall %b want 000", {inst_valid, mem_req, stall}); end
    pc_i = 32'h300; pc_valid = 1'b1; #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL rstmiss_not_filled: got stall %b want 1", stall); end
    pc_valid = 1'b0;
  endtask

  initial begin
    test_reset;
    test_cold_miss;
    test_alias;
    test_ctrl_hold;
    test_flush;
    test_rdy_freeze;
    test_inv_all;
    test_rst_mid_miss;
    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache_fetch.md
ICACHE_FETCH -- requirements
Module: icache_fetch

Interface
REQ-001 Parameter ADDR_W, 32, byte address width.
REQ-002 Parameter INST_W, 32, instruction width.
REQ-003 Parameter IDX_W, 8, cache index bits (2**IDX_W direct-mapped single-word lines).
REQ-004 Parameter CTRL_STALL, 1, nonzero: hold fetch after JAL/JALR/BRANCH until resolved.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 rdy  in  1  global enable; low freezes all state.
REQ-008 pc_i  in  ADDR_W  fetch address from PC register.
REQ-009 pc_valid  in  1  pc_i valid this cycle.
REQ-010 flush  in  1  discard in-flight/pending fetch (redirect).
REQ-011 ctrl_done  in  1  one-cycle pulse: control-flow instruction resolved.
REQ-012 inv_all  in  1  invalidate whole cache (fence.i).
REQ-013 pc_o  out  ADDR_W  address of delivered instruction.
REQ-014 inst_o  out  INST_W  delivered instruction.
REQ-015 inst_valid  out  1  pc_o/inst_o valid, one-cycle pulse per instruction.
REQ-016 stall  out  1  PC register must not advance.
REQ-017 mem_addr  out  ADDR_W  miss address to memory controller.
REQ-018 mem_req  out  1  memory read request, level, held until mem_done.
REQ-019 mem_data  in  INST_W  returned word, valid with mem_done.
REQ-020 mem_done  in  1  one-cycle completion pulse.

Function
REQ-021 Line: valid bit, tag = pc[ADDR_W-1:IDX_W+2], data word; index = pc[IDX_W+1:2]; pc[1:0] ignored.
REQ-022 States RUN, MISS, HOLD; reset state RUN.
REQ-023 RUN, pc_valid, hit: next cycle inst_valid=1, inst_o=line data, pc_o=pc_i (latency 1).
REQ-024 RUN, pc_valid, miss: same cycle stall=1; next cycle mem_req=1, mem_addr=pc_i; go MISS.
REQ-025 MISS: mem_req/mem_addr held constant, stall=1 until mem_done.
REQ-026 MISS, mem_done: write line (valid=1, tag, mem_data); next cycle inst_valid=1 with mem_data and miss pc; mem_req=0; go RUN (or HOLD per REQ-027).
REQ-027 CTRL_STALL!=0 and delivered opcode[6:0] in {1101111, 1100111, 1100011}: go HOLD, stall=1 until ctrl_done; ctrl_done -> RUN next cycle.
REQ-028 ctrl_done in the same cycle as entry to HOLD: no hold (RUN).
REQ-029 flush in RUN or HOLD: suppress that cycle's delivery, go RUN.
REQ-030 flush in MISS: fill still completes and is written; delivery suppressed; go RUN after mem_done.
REQ-031 inv_all: clear all valid bits at next edge; a fill completing same cycle is also cleared; a hit lookup the same cycle still delivers.
REQ-032 rdy=0: no state, cache or output change; mem_req holds its value; mem_done while rdy=0 is captured and acted on when rdy returns.
REQ-033 stall = (state!=RUN) | (RUN & pc_valid & miss); never asserted spuriously in RUN on hit.
REQ-034 At most one outstanding mem_req.

Reset
REQ-035 rst: state RUN, all valid bits 0, pc_o/inst_o/mem_addr 0, inst_valid/stall/mem_req 0, captured mem_done flag 0.
REQ-036 rst mid-MISS abandons the request; a later stray mem_done is ignored.

Structure
REQ-037 Shared package: state encoding, opcode constants (JAL, JALR, BRANCH), ZERO_WORD.
REQ-038 One sub-module icache_dm_array (tag/valid/data storage, read port, write port, bulk invalidate).

Verification
REQ-039 Cold fetch 0x00000010, mem_done after 3 cycles with 0x00000013 -> mem_req 3 cycles, inst_valid once with inst_o 0x00000013; refetch 0x10 hits, latency 1, mem_req 0.
REQ-040 Aliasing: fetch 0x10 then 0x410 (IDX_W=8) -> second misses, evicts; refetch 0x10 misses again.
REQ-041 Deliver 0x0000006F (JAL) -> stall stays 1 in HOLD; ctrl_done pulse -> stall 0 next cycle; with CTRL_STALL=0 no hold.
REQ-042 flush during MISS -> no inst_valid for that fetch; subsequent fetch of same pc hits.
REQ-043 rdy low 5 cycles during MISS with mem_done inside -> outputs frozen; delivery on first rdy-high cycle after.
REQ-044 inv_all after filling 4 lines -> all 4 refetches miss; rst mid-MISS -> mem_req 0, stray mem_done ignored.
